// File: rtl/pipelined_wallace_multiplier.sv
// pipelined_wallace_multiplier: unsigned WIDTH x WIDTH multiplier; a partial-product rank feeds a
// carry-save (Wallace) tree plus final adder spread over STAGES ranks, with optional low-column truncation.
module pipelined_wallace_multiplier #(
    parameter int WIDTH       = 8,
    parameter int STAGES      = 2,
    parameter int APPROX_COLS = 4,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 approx,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_approx,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int PW = 2 * WIDTH;
    typedef logic [WIDTH-1:0][PW-1:0] rows_t;

    function automatic int next_rows(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int tree_levels();
        int n;
        int l;
        n = WIDTH;
        l = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (n > 2) begin
                n = next_rows(n);
                l++;
            end
        end
        return l;
    endfunction

    // Tree levels plus one final carry-propagate step, distributed evenly over the ranks.
    localparam int LEVELS = tree_levels();
    localparam int STEPS  = LEVELS + 1;

    function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic apx);
        rows_t o;
        o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                o[i][i+j] = a[i] & b[j] & ~(apx && (i + j < APPROX_COLS));
            end
        end
        return o;
    endfunction

    // One Wallace level: each group of three rows becomes a sum row and a shifted carry row.
    function automatic rows_t csa_level(input rows_t r, input int n);
        rows_t o;
        int g;
        o = '0;
        g = n / 3;
        for (int i = 0; i < WIDTH / 3; i++) begin
            if (i < g) begin
                o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
                o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            if (k >= 3 * g && k < n) o[k-g] = r[k];
        end
        return o;
    endfunction

    function automatic rows_t cpa(input rows_t r);
        rows_t o;
        o = '0;
        o[0] = r[0] + r[1];
        return o;
    endfunction

    function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
        rows_t o;
        int n;
        o = r;
        n = WIDTH;
        for (int l = 0; l < STEPS; l++) begin
            if (l >= lo && l < hi) o = (l == LEVELS) ? cpa(o) : csa_level(o, n);
            n = next_rows(n);
        end
        return o;
    endfunction

    logic [STAGES:0]  vld_q, vld_d;
    logic [STAGES:0]  apx_q, apx_d;
    logic [TAG_W-1:0] tag_q [0:STAGES];
    logic [TAG_W-1:0] tag_d [0:STAGES];
    rows_t            rows_q [0:STAGES];
    rows_t            rows_d [0:STAGES];
    logic             adv;

    always_comb begin
        adv       = !vld_q[STAGES] || out_ready;
        vld_d     = adv ? {vld_q[STAGES-1:0], in_valid} : vld_q;
        apx_d     = adv ? {apx_q[STAGES-1:0], approx} : apx_q;
        tag_d[0]  = adv ? in_tag : tag_q[0];
        rows_d[0] = adv ? gen_pp(in1, in2, approx) : rows_q[0];
        for (int s = 1; s <= STAGES; s++) begin
            tag_d[s]  = adv ? tag_q[s-1] : tag_q[s];
            rows_d[s] = adv ? reduce(rows_q[s-1], (s - 1) * STEPS / STAGES, s * STEPS / STAGES) : rows_q[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            apx_q <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                tag_q[s]  <= '0;
                rows_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            apx_q <= apx_d;
            for (int s = 0; s <= STAGES; s++) begin
                tag_q[s]  <= tag_d[s];
                rows_q[s] <= rows_d[s];
            end
        end
    end

    assign in_ready   = adv;
    assign out        = rows_q[STAGES][0];
    assign out_tag    = tag_q[STAGES];
    assign out_approx = apx_q[STAGES];
    assign out_valid  = vld_q[STAGES];
endmodule

// File: doc/pipelined_wallace_multiplier.md
# pipelined_wallace_multiplier

Parametrised, pipelined unsigned Wallace-tree multiplier with a valid/ready stream handshake and a run-time selectable approximate mode. In approximate mode, the low-order partial-product columns are dropped. It is the sequential successor to the team's combinational 8-bit Wallace multiplier. It sits between operand sources and accumulation/error-analysis logic in the approximate-multiplier datapath.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 4–32.
- `STAGES`, default 2: pipeline register stages; legal range 1–4; sets the latency.
- `APPROX_COLS`, default 4: number of low partial-product columns discarded in approximate mode; legal range 0–2*WIDTH-1.
- `TAG_W`, default 4: width of the side-band tag carried alongside each operation.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `in1`, input, WIDTH: unsigned multiplicand.
- `in2`, input, WIDTH: unsigned multiplier.
- `approx`, input, 1: 1 selects approximate mode; sampled with the operands.
- `in_tag`, input, TAG_W: tag, returned unchanged with the result.
- `in_valid`, input, 1: operands present.
- `in_ready`, output, 1: block can accept operands this cycle.
- `out`, output, 2*WIDTH: product.
- `out_tag`, output, TAG_W: tag of the result currently on `out`.
- `out_approx`, output, 1: mode the result was computed in.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.

## Operation
- Partial products: pp[i][j] = in1[i] & in2[j]; column of pp[i][j] is c = i+j.
- Exact mode (`approx`=0): out = in1*in2, full 2*WIDTH bits, no truncation or overflow.
- Approximate mode (`approx`=1): every pp with i+j < APPROX_COLS is forced to 0 before reduction.
  - out = sum of the remaining pp[i][j]·2^(i+j).
  - No compensation constant is added.
  - APPROX_COLS=0 makes approximate mode identical to exact mode.
- Reduction uses a Wallace tree of full and half adders, finished by a final carry-propagate adder.
  - The tree levels are split across STAGES register boundaries.
  - Stage partitioning is implementation-chosen, but latency must match the Timing section.
- Each pipeline stage holds a valid bit. Tag and mode bits travel alongside the data through every stage.
- Global advance enable: adv = !out_valid | out_ready.
  - When adv=1, all stages shift by one.
  - When adv=0, all stages hold their contents.
  - in_ready = adv.
- An operation is accepted when in_valid & in_ready. When in_valid=0 on an advancing cycle, a bubble (valid=0) enters the pipeline.
- No operation is dropped or duplicated under any pattern of in_valid and out_ready.

## Timing
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES, assuming no stall occurs.
  - Each cycle with adv=0 adds one cycle of latency.
- Throughput: one operation per cycle while out_ready=1.
- Reset (rst=1 at an edge):
  - All stage valid bits clear; out_valid=0.
  - out=0, out_tag=0, out_approx=0.
  - in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight operations are discarded and no result for them ever appears. Any in_valid presented while rst=1 is ignored.
- `out`, `out_tag` and `out_approx` are registered. They are held stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit (in_valid=1, out_valid=1, out_ready=1): both occur on the same edge.
- Pipeline full with out_ready=0: in_ready=0 combinationally, in the same cycle.

## Test plan
- WIDTH=8, STAGES=2, exact mode: 122×122 with tag 5 → out=14884 (0x3A24), out_tag=5, out_approx=0, out_valid exactly 2 cycles after accept.
- Same operands, approx=1, APPROX_COLS=4 → out=14880 (pp[1][1] in column 2 dropped). Also 255×255 exact → 65025, and 0×200 → 0.
- Back-to-back stream of 50 random exact-mode pairs with out_ready held at 1 → one result per cycle, in order, each equal to in1*in2, tags matching.
- Stream of 20 ops with out_ready toggled pseudo-randomly:
  - out and out_tag stay stable while stalled;
  - in_ready=0 only when out_valid=1 and out_ready=0;
  - all 20 results arrive in order, with no loss and no duplicates.
- Assert rst for one cycle while 2 ops are in flight → out_valid=0 next cycle and outputs 0; a new op accepted afterwards returns its correct product; no stale results appear.
- Sweep WIDTH=4/16, STAGES=1/4, APPROX_COLS=0 → approximate output equals exact output for all 256 4-bit pairs, and latency equals STAGES.
